// File: rtl/simon_param_core.sv
// -----------------------------------------------------------------------------
// simon_param_core
// Iterative SIMON block cipher: on-chip key expansion (one round key per
// cycle) followed by encryption or decryption (one round per cycle).
//
// Parameters
//   N  : word size in bits (16, 24, 32, 48, 64)
//   M  : number of key words (2, 3, 4)
//   T  : number of rounds for the (N, M) pair
//   Co : z-sequence index 0..4. Any other value selects the z sequence from
//        the standard SIMON (N, M) table. The default of 7 therefore gives z2
//        for the default N=64, M=2 build.
//
// Ports
//   clk      in   rising-edge clock
//   R        in   synchronous active-high reset
//   newData  in   request to process the block on plain
//   newKey   in   request to expand the key on key
//   enc_dec  in   1 = encrypt, 0 = decrypt (captured together with plain)
//   readData in   host has consumed cipher
//   plain    in   2N-bit block, x in the upper half and y in the lower half
//   key      in   M key words, key[0] = k0
//   ldData   out  one-cycle pulse: plain and enc_dec captured
//   ldKey    out  one-cycle pulse: key captured
//   doneData out  high while the result on cipher is valid
//   doneKey  out  high while a complete round-key schedule is held
//   cipher   out  2N-bit result block, same x/y packing as plain
//
// Build option
//   SIMON_CBC_EN : adds iv / ivLoad ports and a 2N-bit chaining register
//                  (CBC mode). Left undefined, the core is ECB only.
// -----------------------------------------------------------------------------
module simon_param_core #(
  parameter int N  = 64,
  parameter int M  = 2,
  parameter int T  = 68,
  parameter int Co = 7
) (
  input  logic                clk,
  input  logic                R,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [2*N-1:0]      plain,
  input  logic [M-1:0][N-1:0] key,
`ifdef SIMON_CBC_EN
  input  logic [2*N-1:0]      iv,
  input  logic                ivLoad,
`endif
  output logic                ldData,
  output logic                ldKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [2*N-1:0]      cipher
);

  localparam int KW = $clog2(T);

  // Map (N, M) to its z sequence when Co does not name one directly.
  function automatic int z_index(input int co);
    if (co >= 0 && co <= 4) return co;
    if (M == 4) return (N == 16) ? 0 : (N == 24) ? 1 : (N == 32) ? 3 : 4;
    if (M == 3) return (N == 24) ? 0 : (N == 32) ? 2 : 3;
    return 2;
  endfunction

  // Bit i of each constant is z_j[i].
  function automatic logic [61:0] z_const(input int idx);
    case (idx)
      0:       return 62'h19C3522FB386A45F;
      1:       return 62'h16864FB8AD0C9F71;
      2:       return 62'h3369F885192C0EF5;
      3:       return 62'h3C2CE51207A635DB;
      default: return 62'h3DC94C3A046D678B;
    endcase
  endfunction

  localparam logic [61:0]   ZSEQ   = z_const(z_index(Co));
  localparam logic [N-1:0]  C_KS   = {{(N-2){1'b1}}, 2'b00};
  localparam logic [KW-1:0] M_K    = KW'(M);
  localparam logic [KW-1:0] T_LAST = KW'(T - 1);

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] f_round(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t           r_state, w_next;
  logic             w_take_key, w_take_data;
  logic [N-1:0]     r_rk [T];
  logic [KW-1:0]    r_kcnt, r_rnd;
  logic [5:0]       r_zidx;
  logic             r_fin, r_enc;
  logic             r_ld_data, r_ld_key, r_done_data, r_done_key;
  logic [N-1:0]     r_x, r_y;
  logic [2*N-1:0]   r_cipher;
  logic [N-1:0]     w_ks_tmp, w_new_rk, w_rk, w_x_nx, w_y_nx;
  logic [2*N-1:0]   w_blk_in, w_blk_out;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (R) r_state <= IDLE;
    else   r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_take_key  = 1'b0;
    w_take_data = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A new key wins over a pending block.
        if (newKey) begin
          w_take_key = 1'b1;
          w_next     = KEYEXP;
        end else if (newData && r_done_key) begin
          w_take_data = 1'b1;
          w_next      = ROUND;
        end
      end
      KEYEXP:  if (r_kcnt == T_LAST) w_next = IDLE;
      ROUND:   if (r_fin)            w_next = DONE;
      DONE:    if (readData)         w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------- key schedule
  always_comb begin
    w_ks_tmp = rol(r_rk[r_kcnt - KW'(1)], N - 3);
    if (M == 4) w_ks_tmp = w_ks_tmp ^ r_rk[r_kcnt - KW'(3)];
    w_ks_tmp = w_ks_tmp ^ rol(w_ks_tmp, N - 1);
    w_new_rk = r_rk[r_kcnt - M_K] ^ w_ks_tmp ^ C_KS ^ {{(N-1){1'b0}}, ZSEQ[r_zidx]};
  end

  // ------------------------------------------------------------ round logic
  always_comb begin
    w_rk = r_enc ? r_rk[r_rnd] : r_rk[T_LAST - r_rnd];
    if (r_enc) begin
      w_x_nx = r_y ^ f_round(r_x) ^ w_rk;
      w_y_nx = r_x;
    end else begin
      w_x_nx = r_y;
      w_y_nx = r_x ^ f_round(r_y) ^ w_rk;
    end
  end

`ifdef SIMON_CBC_EN
  logic [2*N-1:0] r_chain, r_pblk, w_chain_in;

  assign w_chain_in = ivLoad ? iv : r_chain;
  assign w_blk_in   = enc_dec ? (plain ^ w_chain_in) : plain;
  assign w_blk_out  = r_enc ? {r_x, r_y} : ({r_x, r_y} ^ r_chain);

  always_ff @(posedge clk) begin
    if (R) begin
      r_chain <= '0;
      r_pblk  <= '0;
    end else if (w_take_data) begin
      r_chain <= w_chain_in;
      r_pblk  <= plain;
    end else if (r_state == ROUND && r_fin) begin
      // Encrypt chains on its own output, decrypt on the ciphertext it consumed.
      r_chain <= r_enc ? w_blk_out : r_pblk;
    end
  end
`else
  assign w_blk_in  = plain;
  assign w_blk_out = {r_x, r_y};
`endif

  // NOTE: the round-key store has no reset; doneKey alone says whether its
  // contents are usable, which keeps the array free of reset fan-out.
  always_ff @(posedge clk) begin
    if (!R) begin
      if (w_take_key) begin
        for (int j = 0; j < M; j++) r_rk[j] <= key[j];
      end else if (r_state == KEYEXP) begin
        r_rk[r_kcnt] <= w_new_rk;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (R) begin
      r_ld_data   <= 1'b0;
      r_ld_key    <= 1'b0;
      r_done_data <= 1'b0;
      r_done_key  <= 1'b0;
      r_cipher    <= '0;
      r_kcnt      <= '0;
      r_zidx      <= '0;
      r_rnd       <= '0;
      r_fin       <= 1'b0;
      r_enc       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      r_ld_data <= w_take_data;
      r_ld_key  <= w_take_key;

      if (w_take_key) begin
        r_done_key <= 1'b0;
        r_kcnt     <= M_K;
        r_zidx     <= '0;
      end

      if (r_state == KEYEXP) begin
        r_kcnt <= r_kcnt + KW'(1);
        r_zidx <= (r_zidx == 6'd61) ? 6'd0 : r_zidx + 6'd1;
        if (r_kcnt == T_LAST) r_done_key <= 1'b1;
      end

      if (w_take_data) begin
        {r_x, r_y} <= w_blk_in;
        r_enc      <= enc_dec;
        r_rnd      <= '0;
        r_fin      <= 1'b0;
      end

      // T round cycles, then one output cycle that publishes the result.
      if (r_state == ROUND) begin
        if (!r_fin) begin
          r_x   <= w_x_nx;
          r_y   <= w_y_nx;
          r_rnd <= r_rnd + KW'(1);
          if (r_rnd == T_LAST) r_fin <= 1'b1;
        end else begin
          r_cipher    <= w_blk_out;
          r_done_data <= 1'b1;
        end
      end

      if (r_state == DONE && readData) r_done_data <= 1'b0;
    end
  end

  assign ldData   = r_ld_data;
  assign ldKey    = r_ld_key;
  assign doneData = r_done_data;
  assign doneKey  = r_done_key;
  assign cipher   = r_cipher;

endmodule
